// File: rtl/cpu_pkg.sv
// Shared definitions for the pipeline-to-ram read front end:
// default widths, responder FSM encoding and requester port IDs.
package cpu_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  // Wide enough for RAM_LATENCY up to 7.
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } state_e;

  typedef enum logic {
    PORT_STAGE12 = 1'b0,
    PORT_STAGE3  = 1'b1
  } port_e;

endpackage

// File: rtl/ram_rr_arbiter.sv
// Two-requester round-robin arbiter; bit i of req/grant is port ID i.
// Purely combinational: on a tie the port that did not win last time wins.
module ram_rr_arbiter
  import cpu_pkg::*;
(
  input  logic [1:0] req,
  input  port_e      last_grant,
  output logic [1:0] grant,
  output logic       valid
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant == PORT_STAGE12) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
    valid = |grant;
  end

endmodule

// File: rtl/ram_read_responder.sv
// Arbitrates stage12/stage3 read requests onto a synchronous single-port ram
// and answers each with a 4-phase read/ready handshake.
module ram_read_responder
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int RAM_LATENCY = 1
) (
  input  logic              ram_clk,
  input  logic              rst,
  input  logic              stage12_read,
  input  logic [ADDR_W-1:0] stage12_read_address,
  output logic              stage12_read_ready,
  output logic [DATA_W-1:0] stage12_read_data_out,
  input  logic              stage3_read,
  input  logic [ADDR_W-1:0] stage3_read_address,
  output logic              stage3_read_ready,
  output logic [DATA_W-1:0] stage3_read_data_out,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_data_out
);

  state_e           state, state_next;
  port_e            last_grant, active, grant_port;
  logic [1:0]       grant;
  logic             grant_valid;
  logic             active_read;
  logic [CNT_W-1:0] cnt;

  ram_rr_arbiter u_arbiter (
    .req        ({stage3_read, stage12_read}),
    .last_grant (last_grant),
    .grant      (grant),
    .valid      (grant_valid)
  );

  assign mem_write_enable = 1'b0;
  assign grant_port       = grant[1] ? PORT_STAGE3 : PORT_STAGE12;
  assign active_read      = (active == PORT_STAGE12) ? stage12_read : stage3_read;

  always_ff @(posedge ram_clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_valid) state_next = WAIT;
      WAIT:    if (cnt == '0)   state_next = RESPOND;
      RESPOND: if (!active_read) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The counter is loaded at grant and reaches zero once RAM_LATENCY edges
  // have passed with mem_address stable; the following edge captures data.
  always_ff @(posedge ram_clk or posedge rst) begin
    if (rst) begin
      last_grant            <= PORT_STAGE3;
      active                <= PORT_STAGE12;
      cnt                   <= '0;
      mem_address           <= '0;
      stage12_read_ready    <= 1'b0;
      stage3_read_ready     <= 1'b0;
      stage12_read_data_out <= '0;
      stage3_read_data_out  <= '0;
    end else begin
      case (state)
        IDLE: if (grant_valid) begin
          active      <= grant_port;
          last_grant  <= grant_port;
          mem_address <= grant[1] ? stage3_read_address : stage12_read_address;
          cnt         <= CNT_W'(RAM_LATENCY);
        end
        WAIT: begin
          if (cnt == '0) begin
            if (active == PORT_STAGE12) begin
              stage12_read_data_out <= mem_data_out;
              stage12_read_ready    <= 1'b1;
            end else begin
              stage3_read_data_out  <= mem_data_out;
              stage3_read_ready     <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESPOND: if (!active_read) begin
          stage12_read_ready <= 1'b0;
          stage3_read_ready  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_read_responder.sv
// Directed bench for ram_read_responder: default-latency instance plus a
// RAM_LATENCY=3 instance, each driven against a behavioural synchronous ram.
module tb_ram_read_responder;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;

  // Instance A: RAM_LATENCY = 1
  logic              a12_read, a3_read;
  logic [ADDR_W-1:0] a12_addr, a3_addr;
  logic              a12_ready, a3_ready;
  logic [DATA_W-1:0] a12_data, a3_data;
  logic              a_we;
  logic [ADDR_W-1:0] a_maddr;
  logic [DATA_W-1:0] a_mdata;

  // Instance B: RAM_LATENCY = 3
  logic              b12_read, b3_read;
  logic [ADDR_W-1:0] b12_addr, b3_addr;
  logic              b12_ready, b3_ready;
  logic [DATA_W-1:0] b12_data, b3_data;
  logic              b_we;
  logic [ADDR_W-1:0] b_maddr;
  logic [DATA_W-1:0] b_mdata;

  logic [DATA_W-1:0] ram [0:255];
  logic [DATA_W-1:0] b_pipe [0:2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_read_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_LATENCY(1)) dut (
    .ram_clk               (clk),
    .rst                   (rst),
    .stage12_read          (a12_read),
    .stage12_read_address  (a12_addr),
    .stage12_read_ready    (a12_ready),
    .stage12_read_data_out (a12_data),
    .stage3_read           (a3_read),
    .stage3_read_address   (a3_addr),
    .stage3_read_ready     (a3_ready),
    .stage3_read_data_out  (a3_data),
    .mem_write_enable      (a_we),
    .mem_address           (a_maddr),
    .mem_data_out          (a_mdata)
  );

  ram_read_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_LATENCY(3)) dut3 (
    .ram_clk               (clk),
    .rst                   (rst),
    .stage12_read          (b12_read),
    .stage12_read_address  (b12_addr),
    .stage12_read_ready    (b12_ready),
    .stage12_read_data_out (b12_data),
    .stage3_read           (b3_read),
    .stage3_read_address   (b3_addr),
    .stage3_read_ready     (b3_ready),
    .stage3_read_data_out  (b3_data),
    .mem_write_enable      (b_we),
    .mem_address           (b_maddr),
    .mem_data_out          (b_mdata)
  );

  // Behavioural rams: one registered stage for A, three for B.
  always @(posedge clk) a_mdata <= ram[a_maddr[7:0]];

  always @(posedge clk) begin
    b_pipe[0] <= ram[b_maddr[7:0]];
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end
  assign b_mdata = b_pipe[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = '0;
    ram[8'h00] = 8'h01;
    ram[8'h04] = 8'h02;
    ram[8'h10] = 8'h5A;
    ram[8'h20] = 8'h77;

    rst = 1'b0;
    a12_read = 1'b0; a3_read = 1'b0; a12_addr = '0; a3_addr = '0;
    b12_read = 1'b0; b3_read = 1'b0; b12_addr = '0; b3_addr = '0;

    // Reset state
    #1 rst = 1'b1;
    #2;
    check("rst_ready12", 32'(a12_ready), 32'd0);
    check("rst_ready3",  32'(a3_ready),  32'd0);
    check("rst_data12",  32'(a12_data),  32'd0);
    check("rst_maddr",   32'(a_maddr),   32'd0);
    check("rst_we",      32'(a_we),      32'd0);
    tick(); tick();
    rst = 1'b0;

    // Single stage12 read of address 0: ready two edges after grant
    a12_read = 1'b1; a12_addr = 16'h0000;
    tick();
    check("t1_ready_e0", 32'(a12_ready), 32'd0);
    tick();
    check("t1_ready_e1", 32'(a12_ready), 32'd0);
    tick();
    check("t1_ready_e2", 32'(a12_ready), 32'd1);
    check("t1_data",     32'(a12_data),  32'h01);
    check("t1_ready3",   32'(a3_ready),  32'd0);
    a12_read = 1'b0;
    tick();
    check("t1_drop",     32'(a12_ready), 32'd0);
    check("t1_hold",     32'(a12_data),  32'h01);

    // Tie after reset: stage12 first, then stage3; stage3 address changed mid-WAIT
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a12_read = 1'b1; a12_addr = 16'h0004;
    a3_read  = 1'b1; a3_addr  = 16'h0010;
    tick();
    check("t2_maddr12", 32'(a_maddr), 32'h0004);
    tick(); tick();
    check("t2_ready12", 32'(a12_ready), 32'd1);
    check("t2_data12",  32'(a12_data),  32'h02);
    check("t2_ready3a", 32'(a3_ready),  32'd0);
    a12_read = 1'b0;
    tick();
    check("t2_drop12",  32'(a12_ready), 32'd0);
    tick();
    check("t2_maddr3",  32'(a_maddr), 32'h0010);
    a3_addr = 16'h0020;
    tick();
    check("t2_ready3_e1", 32'(a3_ready), 32'd0);
    tick();
    check("t2_ready3",  32'(a3_ready),  32'd1);
    check("t2_data3",   32'(a3_data),   32'h5A);
    check("t2_keep12",  32'(a12_data),  32'h02);
    check("t2_ready12b", 32'(a12_ready), 32'd0);
    a3_read = 1'b0;
    tick();
    check("t2_drop3",   32'(a3_ready),  32'd0);
    check("t2_latched", 32'(a_maddr),   32'h0010);

    // Both requesters keep re-requesting: grants alternate 12,3,12,3
    a12_addr = 16'h0004; a3_addr = 16'h0010;
    a12_read = 1'b1; a3_read = 1'b1;
    for (int t = 0; t < 4; t++) begin
      int n;
      logic exp3;
      n = 0;
      exp3 = t[0];
      while (!(a12_ready || a3_ready) && n < 10) begin
        tick();
        n++;
      end
      check($sformatf("t3_latency_%0d", t), 32'(n), 32'd3);
      check($sformatf("t3_ready12_%0d", t), 32'(a12_ready), 32'(!exp3));
      check($sformatf("t3_ready3_%0d", t),  32'(a3_ready),  32'(exp3));
      if (exp3) begin
        check($sformatf("t3_data3_%0d", t), 32'(a3_data), 32'h5A);
        a3_read = 1'b0;
      end else begin
        check($sformatf("t3_data12_%0d", t), 32'(a12_data), 32'h02);
        a12_read = 1'b0;
      end
      tick();
      check($sformatf("t3_gap_%0d", t), 32'({a12_ready, a3_ready}), 32'd0);
      a12_read = 1'b1; a3_read = 1'b1;
    end
    a12_read = 1'b0; a3_read = 1'b0;
    tick();

    // Reset during WAIT, then tie resolves to stage12 again
    a12_read = 1'b1; a12_addr = 16'h0000;
    tick();
    check("t5_wait_maddr", 32'(a_maddr), 32'h0000);
    a3_read = 1'b1; a3_addr = 16'h0010;
    #2 rst = 1'b1;
    #1;
    check("t5_rst_ready",  32'({a12_ready, a3_ready}), 32'd0);
    check("t5_rst_data12", 32'(a12_data), 32'd0);
    check("t5_rst_data3",  32'(a3_data),  32'd0);
    check("t5_rst_maddr",  32'(a_maddr),  32'd0);
    tick();
    rst = 1'b0;
    tick(); tick();
    check("t5_early", 32'({a12_ready, a3_ready}), 32'd0);
    tick();
    check("t5_ready12", 32'(a12_ready), 32'd1);
    check("t5_ready3",  32'(a3_ready),  32'd0);
    check("t5_data12",  32'(a12_data),  32'h01);
    a12_read = 1'b0; a3_read = 1'b0;
    tick();

    // RAM_LATENCY = 3: ready four edges after the grant edge
    b3_read = 1'b1; b3_addr = 16'h0020;
    tick();
    check("t6_maddr", 32'(b_maddr), 32'h0020);
    tick(); tick(); tick();
    check("t6_ready_e3", 32'(b3_ready), 32'd0);
    tick();
    check("t6_ready_e4", 32'(b3_ready), 32'd1);
    check("t6_data",     32'(b3_data),  32'h77);
    check("t6_ready12",  32'(b12_ready), 32'd0);
    check("t6_we",       32'(b_we),     32'd0);
    b3_read = 1'b0;
    tick();
    check("t6_drop", 32'(b3_ready), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
